// File: rtl/fetch_ir_stage_if.sv
// Bus between the fetch side (instruction memory, hazard/branch logic, CU fetch
// control) and the IF/ID boundary register.
interface fetch_ir_stage_if #(
  parameter int unsigned W = 8
) ();
  logic [W-1:0] instr_in;
  logic [W-1:0] pc_in;
  logic         stall;
  logic         flush;
  logic         sf1;
  logic [W-1:0] IR;
  logic [W-1:0] imm;
  logic [W-1:0] pc_plus1;
  logic         reg_sf1;
  logic         ir_valid;
  logic         imm_phase;
  logic         sf1_pending;

  modport master (
    output instr_in, pc_in, stall, flush, sf1,
    input  IR, imm, pc_plus1, reg_sf1, ir_valid, imm_phase, sf1_pending
  );

  modport slave (
    input  instr_in, pc_in, stall, flush, sf1,
    output IR, imm, pc_plus1, reg_sf1, ir_valid, imm_phase, sf1_pending
  );
endinterface

// File: rtl/fetch_ir_stage.sv
// IF/ID boundary register: captures one- and two-byte instructions, injects the
// PC on interrupt entry at instruction boundaries, and honours stall/flush.
// All outputs come straight from flops.
module fetch_ir_stage #(
  parameter int unsigned  W           = 8,
  parameter logic [3:0]   TWO_BYTE_OP = 4'd12,
  parameter logic [W-1:0] NOP         = '0
) (
  input logic            clk,
  input logic            rst,
  fetch_ir_stage_if.slave bus
);

  typedef enum logic [0:0] {SOp, SImm} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] ir_q, ir_d;
  logic [W-1:0] imm_q, imm_d;
  logic [W-1:0] pc_plus1_q, pc_plus1_d;
  logic         reg_sf1_q, reg_sf1_d;
  logic         ir_valid_q, ir_valid_d;
  logic         sf1_pending_q, sf1_pending_d;

  // Next-state: flush > stall > injection > normal capture.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    imm_d         = imm_q;
    pc_plus1_d    = pc_plus1_q;
    reg_sf1_d     = reg_sf1_q;
    ir_valid_d    = ir_valid_q;
    sf1_pending_d = sf1_pending_q;

    if (bus.flush) begin
      // Pending interrupt survives a flush; pc_plus1 is left alone.
      ir_d       = NOP;
      imm_d      = '0;
      ir_valid_d = 1'b0;
      reg_sf1_d  = 1'b0;
      state_d    = SOp;
    end else if (!bus.stall) begin
      unique case (state_q)
        SOp: begin
          if (bus.sf1 || sf1_pending_q) begin
            // Injected PC is not an opcode, so never enters SImm.
            ir_d          = bus.pc_in;
            pc_plus1_d    = bus.pc_in;
            reg_sf1_d     = 1'b1;
            ir_valid_d    = 1'b1;
            sf1_pending_d = 1'b0;
          end else begin
            ir_d       = bus.instr_in;
            pc_plus1_d = bus.pc_in + {{(W-1){1'b0}}, 1'b1};
            reg_sf1_d  = 1'b0;
            if (bus.instr_in[W-1 -: 4] == TWO_BYTE_OP) begin
              ir_valid_d = 1'b0;
              state_d    = SImm;
            end else begin
              ir_valid_d = 1'b1;
            end
          end
        end
        SImm: begin
          // Defer interrupt so it never splits an instruction.
          imm_d      = bus.instr_in;
          ir_valid_d = 1'b1;
          state_d    = SOp;
          if (bus.sf1) sf1_pending_d = 1'b1;
        end
        default: state_d = SOp;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= SOp;
      ir_q          <= NOP;
      imm_q         <= '0;
      pc_plus1_q    <= '0;
      reg_sf1_q     <= 1'b0;
      ir_valid_q    <= 1'b0;
      sf1_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      imm_q         <= imm_d;
      pc_plus1_q    <= pc_plus1_d;
      reg_sf1_q     <= reg_sf1_d;
      ir_valid_q    <= ir_valid_d;
      sf1_pending_q <= sf1_pending_d;
    end
  end

  // Registered outputs only.
  always_comb begin
    bus.IR          = ir_q;
    bus.imm         = imm_q;
    bus.pc_plus1    = pc_plus1_q;
    bus.reg_sf1     = reg_sf1_q;
    bus.ir_valid    = ir_valid_q;
    bus.imm_phase   = (state_q == SImm);
    bus.sf1_pending = sf1_pending_q;
  end

endmodule
